// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared datapath width and word type for pipeline stages
package datapath_pkg;

   localparam int DATA_W = 64;

   typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/reg_64_if.sv
// rtl/reg_64_if.sv - data/enable bundle between a pipeline stage and its latch
interface reg_64_if import datapath_pkg::*; #(
   parameter int WIDTH = DATA_W
) ();

   logic [WIDTH-1:0] data_in;
   logic             en;
   logic [WIDTH-1:0] data_out;

   modport master (
      output data_in,
      output en,
      input  data_out
   );

   modport slave (
      input  data_in,
      input  en,
      output data_out
   );

endinterface

// File: rtl/reg_64.sv
// rtl/reg_64.sv - enable-gated pipeline register with async active-high reset
// en=0 holds the value, which is how a stage stall is realised.
module reg_64 import datapath_pkg::*; #(
   parameter int               WIDTH     = DATA_W,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic     clk,
   input  logic     rst,
   reg_64_if.slave  bus
);

   logic [WIDTH-1:0] q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= RESET_VAL;
      end else if (bus.en) begin
         q <= bus.data_in;
      end
   end

   assign bus.data_out = q;

`ifndef SYNTHESIS
   a_en_known : assert property (@(posedge clk) disable iff (rst)
      !$isunknown(bus.en));

   a_load : assert property (@(posedge clk) disable iff (rst)
      bus.en |=> (bus.data_out == $past(bus.data_in)));

   a_hold : assert property (@(posedge clk) disable iff (rst)
      !bus.en |=> (bus.data_out == $past(bus.data_out)));

   a_reset_val : assert property (@(posedge clk)
      rst |-> (bus.data_out == RESET_VAL));
`endif

endmodule

// File: tb/tb_reg_64.sv
// tb/tb_reg_64.sv - scoreboard bench for reg_64 at WIDTH=64 and WIDTH=8/RESET_VAL=0xA5
module tb_reg_64;
   import datapath_pkg::*;

   logic clk;
   logic rst;

   reg_64_if #(.WIDTH(64)) bus ();
   reg_64_if #(.WIDTH(8))  bus8 ();

   reg_64 #(.WIDTH(64), .RESET_VAL(64'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   reg_64 #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   int    checks;
   int    failures;
   word_t model;
   word_t exp_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle at a negedge, record the expected post-edge value, land on the next negedge.
   task automatic drive(input logic e, input word_t d);
      bus.en      = e;
      bus.data_in = d;
      if (e) model = d;
      exp_q.push_back(model);
      @(negedge clk);
   endtask

   task automatic test_reset;
      word_t exp;
      rst          = 1'b1;
      bus.en       = 1'b0;
      bus.data_in  = '0;
      bus8.en      = 1'b0;
      bus8.data_in = '0;
      model        = '0;
      #1;
      checks++;
      if (bus.data_out !== 64'h0) begin
         failures++;
         $display("FAIL reset64 got=%h exp=%h", bus.data_out, 64'h0);
      end
      checks++;
      if (bus8.data_out !== 8'hA5) begin
         failures++;
         $display("FAIL reset8 got=%h exp=%h", bus8.data_out, 8'hA5);
      end
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 64'h1234);
      exp = exp_q.pop_front();
      checks++;
      if (bus.data_out !== exp) begin
         failures++;
         $display("FAIL reset_hold got=%h exp=%h", bus.data_out, exp);
      end
   endtask

   task automatic test_load;
      word_t exp;
      drive(1'b1, 64'd9);
      exp = exp_q.pop_front();
      checks++;
      if (bus.data_out !== exp) begin
         failures++;
         $display("FAIL load9 got=%h exp=%h", bus.data_out, exp);
      end
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, word_t'(i));
         exp = exp_q.pop_front();
         checks++;
         if (bus.data_out !== exp) begin
            failures++;
            $display("FAIL load_seq%0d got=%h exp=%h", i, bus.data_out, exp);
         end
      end
   endtask

   task automatic test_hold;
      word_t exp;
      drive(1'b0, 64'd6);
      exp = exp_q.pop_front();
      checks++;
      if (bus.data_out !== exp) begin
         failures++;
         $display("FAIL hold got=%h exp=%h", bus.data_out, exp);
      end
      drive(1'b1, 64'd7);
      exp = exp_q.pop_front();
      checks++;
      if (bus.data_out !== exp) begin
         failures++;
         $display("FAIL hold_release got=%h exp=%h", bus.data_out, exp);
      end
   endtask

   task automatic test_async_reset;
      word_t exp;
      drive(1'b1, 64'hDEADBEEFCAFEF00D);
      exp = exp_q.pop_front();
      checks++;
      if (bus.data_out !== exp) begin
         failures++;
         $display("FAIL async_preload got=%h exp=%h", bus.data_out, exp);
      end
      #2;
      rst = 1'b1;
      #1;
      model = '0;
      checks++;
      if (bus.data_out !== 64'h0) begin
         failures++;
         $display("FAIL async_immediate got=%h exp=%h", bus.data_out, 64'h0);
      end
      @(negedge clk);
      bus.en      = 1'b1;
      bus.data_in = 64'h0123456789ABCDEF;
      @(negedge clk);
      checks++;
      if (bus.data_out !== 64'h0) begin
         failures++;
         $display("FAIL async_held got=%h exp=%h", bus.data_out, 64'h0);
      end
      bus.en = 1'b0;
      rst    = 1'b0;
   endtask

   task automatic test_full_width;
      word_t exp;
      drive(1'b1, 64'hFFFFFFFFFFFFFFFF);
      exp = exp_q.pop_front();
      checks++;
      if (bus.data_out !== exp) begin
         failures++;
         $display("FAIL full_ones got=%h exp=%h", bus.data_out, exp);
      end
      drive(1'b1, 64'h8000000000000001);
      exp = exp_q.pop_front();
      checks++;
      if (bus.data_out !== exp) begin
         failures++;
         $display("FAIL full_ends got=%h exp=%h", bus.data_out, exp);
      end
   endtask

   task automatic test_reset_priority;
      word_t exp;
      rst          = 1'b1;
      model        = '0;
      bus.en       = 1'b1;
      bus.data_in  = 64'h5555555555555555;
      bus8.en      = 1'b1;
      bus8.data_in = 8'h55;
      @(negedge clk);
      checks++;
      if (bus.data_out !== 64'h0) begin
         failures++;
         $display("FAIL prio64 got=%h exp=%h", bus.data_out, 64'h0);
      end
      checks++;
      if (bus8.data_out !== 8'hA5) begin
         failures++;
         $display("FAIL prio8 got=%h exp=%h", bus8.data_out, 8'hA5);
      end
      rst = 1'b0;
      drive(1'b1, 64'h5555555555555555);
      exp = exp_q.pop_front();
      checks++;
      if (bus.data_out !== exp) begin
         failures++;
         $display("FAIL prio64_after got=%h exp=%h", bus.data_out, exp);
      end
      checks++;
      if (bus8.data_out !== 8'h55) begin
         failures++;
         $display("FAIL prio8_after got=%h exp=%h", bus8.data_out, 8'h55);
      end
      bus8.en = 1'b0;
   endtask

   task automatic test_random;
      word_t exp;
      int    bad;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         drive(1'($urandom_range(0, 1)), {$urandom, $urandom});
         exp = exp_q.pop_front();
         checks++;
         if (bus.data_out !== exp) begin
            failures++;
            bad++;
            if (bad <= 10)
               $display("FAIL random%0d got=%h exp=%h", i, bus.data_out, exp);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_load();
      test_hold();
      test_async_reset();
      test_full_width();
      test_reset_priority();
      test_random();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d exp=%0d", exp_q.size(), 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
